// File: rtl/motor_pwm_driver.sv
// Half-bridge PWM gate driver with dead-time insertion, period-boundary duty latching
// and a mid-on-time ADC trigger. Gates, triggers and Faulted are all registered.
module motor_pwm_driver #(
    parameter int unsigned DUTY_WIDTH = 8,
    parameter int unsigned DEAD_TIME  = 2
) (
    input  logic                  c20k,
    input  logic                  reset_n,
    input  logic                  Enable,
    input  logic                  Fault,
    input  logic [DUTY_WIDTH-1:0] MotorSignal,
    output logic                  HighGate,
    output logic                  LowGate,
    output logic                  AdcTrigger,
    output logic                  PeriodStart,
    output logic                  Faulted
);

    localparam int unsigned DEAD_W = 4;
    localparam logic [DUTY_WIDTH-1:0] COUNT_MAX     = '1;
    localparam logic [DUTY_WIDTH-1:0] ADC_LOW_POINT = DUTY_WIDTH'(2 ** (DUTY_WIDTH - 1));
    localparam logic [DEAD_W-1:0]     DEAD_MAX      = DEAD_W'(DEAD_TIME);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} stateT;

    stateT                 state;
    logic [DUTY_WIDTH-1:0] count;
    logic [DUTY_WIDTH-1:0] dutyShadow;
    logic                  raw;
    logic [DEAD_W-1:0]     deadCnt;

    logic [DUTY_WIDTH-1:0] countNext;
    logic [DUTY_WIDTH-1:0] shadowNext;
    logic                  rawNext;
    logic                  deadDone;

    // With zero duty there is no on-time, so sample mid-period on the low side.
    function automatic logic [DUTY_WIDTH-1:0] adcPoint(input logic [DUTY_WIDTH-1:0] duty);
        return (duty == '0) ? ADC_LOW_POINT : (duty >> 1);
    endfunction

    // Next-cycle values used while running; duty is only reloaded at the wrap.
    always_comb begin
        countNext  = count + DUTY_WIDTH'(1);
        shadowNext = (count == COUNT_MAX) ? MotorSignal : dutyShadow;
        rawNext    = (count < dutyShadow);
        deadDone   = (deadCnt == DEAD_MAX);
    end

    // PeriodStart and AdcTrigger are timed to be high in the cycle Count holds the matching value.
    always_ff @(posedge c20k) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            dutyShadow  <= '0;
            raw         <= 1'b0;
            deadCnt     <= '0;
            HighGate    <= 1'b0;
            LowGate     <= 1'b0;
            AdcTrigger  <= 1'b0;
            PeriodStart <= 1'b0;
            Faulted     <= 1'b0;
        end else begin
            HighGate    <= 1'b0;
            LowGate     <= 1'b0;
            AdcTrigger  <= 1'b0;
            PeriodStart <= 1'b0;
            Faulted     <= 1'b0;
            case (state)
                IDLE: begin
                    if (Fault) begin
                        state   <= FAULT;
                        Faulted <= 1'b1;
                    end else if (Enable) begin
                        state       <= RUN;
                        count       <= '0;
                        dutyShadow  <= MotorSignal;
                        raw         <= 1'b0;
                        deadCnt     <= '0;
                        PeriodStart <= 1'b1;
                        AdcTrigger  <= (adcPoint(MotorSignal) == '0);
                    end
                end
                RUN: begin
                    if (Fault || !Enable) begin
                        state   <= Fault ? FAULT : IDLE;
                        Faulted <= Fault;
                        count   <= '0;
                        raw     <= 1'b0;
                        deadCnt <= '0;
                    end else begin
                        count       <= countNext;
                        dutyShadow  <= shadowNext;
                        raw         <= rawNext;
                        if (rawNext != raw) begin
                            deadCnt <= '0;
                        end else if (!deadDone) begin
                            deadCnt <= deadCnt + DEAD_W'(1);
                        end
                        HighGate    <= raw & deadDone;
                        LowGate     <= ~raw & deadDone;
                        PeriodStart <= (countNext == '0);
                        AdcTrigger  <= (countNext == adcPoint(shadowNext));
                    end
                end
                FAULT: begin
                    if (!Enable && !Fault) begin
                        state <= IDLE;
                    end else begin
                        Faulted <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver: a per-cycle reference model feeds an expected
// queue, a monitor compares every cycle, plus per-period gate-width and dead-time checks.
module tb_motor_pwm_driver;

    localparam int unsigned DW     = 8;
    localparam int unsigned DEAD   = 2;
    localparam int          PERIOD = 256;

    typedef struct packed {
        logic hi;
        logic lo;
        logic adc;
        logic ps;
        logic flt;
    } outT;

    logic          c20k;
    logic          reset_n;
    logic          Enable;
    logic          Fault;
    logic [DW-1:0] MotorSignal;
    logic          HighGate;
    logic          LowGate;
    logic          AdcTrigger;
    logic          PeriodStart;
    logic          Faulted;

    motor_pwm_driver #(.DUTY_WIDTH(DW), .DEAD_TIME(DEAD)) dut (
        .c20k        (c20k),
        .reset_n     (reset_n),
        .Enable      (Enable),
        .Fault       (Fault),
        .MotorSignal (MotorSignal),
        .HighGate    (HighGate),
        .LowGate     (LowGate),
        .AdcTrigger  (AdcTrigger),
        .PeriodStart (PeriodStart),
        .Faulted     (Faulted)
    );

    initial c20k = 1'b0;
    always #5 c20k = ~c20k;

    int  vectors     = 0;
    int  miscompares = 0;
    outT expQ[$];

    // Reference model: 0 = idle, 1 = run, 2 = fault. rawHist holds the ideal PWM level
    // per cycle since RUN entry; a gate is on once its level has been steady > DEAD cycles.
    int mState = 0;
    int mCount = 0;
    int mShadow = 0;
    bit rawHist[$];

    int winLeft = 0;
    int hiCnt, loCnt, adcCnt, psCnt;

    function automatic int adcAt(input int d);
        return (d == 0) ? PERIOD / 2 : d / 2;
    endfunction

    task automatic step(input bit rstN, input bit en, input bit flt, input int ms);
        outT e;
        bit  last;
        int  run;
        int  idx;
        @(negedge c20k);
        reset_n     = rstN;
        Enable      = en;
        Fault       = flt;
        MotorSignal = DW'(ms);
        e = '0;
        if (!rstN) begin
            mState = 0; mCount = 0; mShadow = 0;
            rawHist.delete();
        end else begin
            case (mState)
                0: begin
                    if (flt) mState = 2;
                    else if (en) begin
                        mState = 1; mCount = 0; mShadow = ms;
                        rawHist.delete();
                        rawHist.push_back(1'b0);
                    end
                end
                1: begin
                    if (flt || !en) begin
                        mState = flt ? 2 : 0;
                        mCount = 0;
                    end else begin
                        last = rawHist[rawHist.size() - 1];
                        run  = 0;
                        idx  = rawHist.size() - 1;
                        while (idx >= 0 && rawHist[idx] == last) begin
                            run++;
                            idx--;
                        end
                        if (run >= DEAD + 1) begin
                            e.hi = last;
                            e.lo = !last;
                        end
                        rawHist.push_back(mCount < mShadow);
                        if (rawHist.size() > 20) void'(rawHist.pop_front());
                        if (mCount == PERIOD - 1) mShadow = ms;
                        mCount = (mCount + 1) % PERIOD;
                    end
                end
                default: begin
                    if (!en && !flt) mState = 0;
                end
            endcase
        end
        if (mState == 1) begin
            e.ps  = (mCount == 0);
            e.adc = (mCount == adcAt(mShadow));
        end
        e.flt = (mState == 2);
        expQ.push_back(e);
    endtask

    // Monitor: one expected vector per clock edge, plus the dead-time gap on every gate rise.
    initial begin
        outT e;
        outT got;
        bit  prevHi = 1'b0;
        bit  prevLo = 1'b0;
        int  lowRun = 0;
        forever begin
            @(posedge c20k);
            #1;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                got = {HighGate, LowGate, AdcTrigger, PeriodStart, Faulted};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t hi/lo/adc/ps/flt got=%b expected=%b", $time, got, e);
                end
                if ((HighGate && !prevHi) || (LowGate && !prevLo)) begin
                    vectors++;
                    if (lowRun < DEAD) begin
                        miscompares++;
                        $display("FAIL deadgap t=%0t both-low cycles got=%0d expected>=%0d", $time, lowRun, DEAD);
                    end
                end
                lowRun = (!HighGate && !LowGate) ? lowRun + 1 : 0;
                prevHi = HighGate;
                prevLo = LowGate;
                if (winLeft > 0) begin
                    hiCnt  += int'(HighGate);
                    loCnt  += int'(LowGate);
                    adcCnt += int'(AdcTrigger);
                    psCnt  += int'(PeriodStart);
                    winLeft--;
                end
            end
        end
    end

    task automatic checkOne(input string name, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    // Counts gate-on cycles over one full period at steady duty d.
    task automatic measurePeriod(input int d);
        int expHi;
        int expLo;
        hiCnt = 0; loCnt = 0; adcCnt = 0; psCnt = 0;
        winLeft = PERIOD;
        for (int i = 0; i < PERIOD + 1; i++) step(1, 1, 0, d);
        expHi = (d > DEAD) ? d - DEAD : 0;
        // Zero duty never toggles, so the low side stays on the whole period.
        expLo = (d == 0) ? PERIOD : ((PERIOD - d > DEAD) ? PERIOD - d - DEAD : 0);
        checkOne($sformatf("highwidth_d%0d", d), hiCnt, expHi);
        checkOne($sformatf("lowwidth_d%0d", d), loCnt, expLo);
        checkOne($sformatf("adcpulses_d%0d", d), adcCnt, 1);
        checkOne($sformatf("periodstarts_d%0d", d), psCnt, 1);
    endtask

    task automatic runTo(input int target, input int d);
        int i;
        for (i = 0; i < 2 * PERIOD && mCount != target; i++) step(1, 1, 0, d);
        if (mCount != target) begin
            vectors++;
            miscompares++;
            $display("FAIL runto count got=%0d expected=%0d", mCount, target);
        end
    endtask

    initial begin
        reset_n = 1'b0; Enable = 1'b0; Fault = 1'b0; MotorSignal = '0;
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0);

        repeat (300) step(1, 1, 0, 100);
        measurePeriod(100);

        // Duty step mid-period only takes effect at the next wrap.
        runTo(30, 100);
        repeat (600) step(1, 1, 0, 200);
        measurePeriod(200);

        repeat (520) step(1, 1, 0, 0);
        measurePeriod(0);
        repeat (520) step(1, 1, 0, 1);
        measurePeriod(1);
        repeat (520) step(1, 1, 0, 255);
        measurePeriod(255);

        repeat (300) step(1, 1, 0, 100);
        runTo(40, 100);
        step(1, 1, 1, 100);
        repeat (10) step(1, 1, 0, 100);
        repeat (2) step(1, 0, 0, 100);
        repeat (300) step(1, 1, 0, 100);

        runTo(20, 100);
        step(0, 1, 0, 100);
        repeat (300) step(1, 1, 0, 100);
        runTo(60, 100);
        repeat (3) step(1, 0, 0, 100);
        repeat (100) step(1, 1, 0, 100);

        for (int i = 0; i < 20000; i++) begin
            step($urandom_range(0, 499) != 0, $urandom_range(0, 99) != 0,
                 $urandom_range(0, 199) == 0, int'($urandom_range(0, 255)));
        end

        repeat (2) step(1, 0, 0, 0);
        @(posedge c20k);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
